stage_sequencer: RTL and testbench
==================================

# stage_sequencer

Parametrised sequencer for the conversion → processing chain: it issues a conversion request, waits for sample data, then walks NUM_STAGES processing stages (stage 0 = filter, stage 1 = compare in the default build) one at a time with enable/done handshakes. Each stage is guarded by a watchdog timeout. The block supports abort, single-shot or continuous frames, and a wrapping frame counter. It sits between the ADC front end and the datapath stages, replacing the fixed two-stage filter/compare controller.

## Interface
- NUM_STAGES, 2, number of chained stages (≥1); STAGE_W = max(1, $clog2(NUM_STAGES))
- TIMEOUT, 255, max cycles a stage may stay active before error; 0 disables watchdog
- FRAME_W, 8, width of frame counter
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  frame request, sampled in IDLE only
- continuous  in  1  1 = auto-restart after each completed frame
- abort  in  1  return to IDLE from any state
- clear_err  in  1  leave ERROR
- data_ready  in  1  conversion result valid
- stage_done  in  NUM_STAGES  per-stage completion; only active stage's bit honoured
- start_conversion  out  1  one-cycle conversion request pulse
- stage_enable  out  NUM_STAGES  one-hot (or zero) enable of active stage
- busy  out  1  state ≠ IDLE and ≠ ERROR
- frame_done  out  1  one-cycle pulse on last stage completion
- error  out  1  high while in ERROR
- err_stage  out  STAGE_W  index of stage that timed out; held until next error
- frame_count  out  FRAME_W  completed frames, wraps to 0

## Operation
- States: IDLE, CONV, RUN, ERROR. All outputs registered.
- Reset (reset=0): state IDLE, stage index 0, timer 0, frame_count 0, err_stage 0, all outputs 0.
- IDLE: start=1 → CONV; start_conversion=1 on the following cycle only.
- CONV: wait data_ready (no timeout). When data_ready=1 → RUN with stage 0, stage_enable=1<<0, and the timer loaded to 0.
- RUN at stage k: stage_enable[k]=1, and the timer increments every cycle.
  - stage_done[k]=1 and k<NUM_STAGES-1 → stage_enable moves to bit k+1 the next cycle, with no gap cycle; the timer reloads to 0.
  - stage_done[k]=1 and k=NUM_STAGES-1 → stage_enable=0, frame_done pulse, frame_count+1 (mod 2^FRAME_W). Then go to CONV if continuous=1 (start_conversion pulses the same cycle as frame_done), else IDLE.
  - Timer reaching TIMEOUT with no done (TIMEOUT≠0) → ERROR, stage_enable=0, err_stage=k.
- ERROR: error=1, busy=0. clear_err=1 → IDLE. start is ignored while in ERROR.
- abort=1 in CONV/RUN/ERROR → IDLE next cycle. stage_enable=0, no frame_done, frame_count unchanged, error cleared.
- Priorities: abort > stage_done > timeout. If done arrives on the expiry cycle, it counts as success.
- stage_done bits of non-active stages are ignored. start while busy is ignored. continuous is sampled only at last-stage completion.
- A reset assertion mid-frame drops every output to 0 immediately (asynchronous), with no frame_done.

## Timing
- start (cycle n) → start_conversion high at n+1 only.
- data_ready (cycle m) → stage_enable[0] high from m+1.
- stage_done[k] (cycle p) → stage_enable[k] low and stage_enable[k+1] high at p+1.
- Last done (cycle q) → frame_done and frame_count update visible at q+1.
- Timeout: stage_enable[k] high for exactly TIMEOUT cycles. error rises on the next cycle if no done arrives.
- Minimum frame (NUM_STAGES=2, all handshakes immediate) is 4 cycles from start to frame_done.

## Structure
- Shared package/header stage_seq_pkg holds the state encodings (IDLE=2'd0, CONV=2'd1, RUN=2'd2, ERROR=2'd3) and the STAGE_W derivation function.
- One sub-module, stage_timer: a loadable up-counter with width $clog2(TIMEOUT+1), inputs clear/enable, output expired. It is tied off when TIMEOUT=0.
- Stage index is held as binary. stage_enable is decoded from the index in a registered decode.

## Test plan
- Reset then idle: after reset release, all outputs 0. Pulse start → start_conversion high for exactly 1 cycle.
- Nominal frame, defaults: start, data_ready 3 cycles later, stage_done[0] after 5 cycles, stage_done[1] after 2 cycles. Expect stage_enable=01 then 10 with no gap, one frame_done pulse, frame_count=1, busy low afterwards.
- Timeout, TIMEOUT=4: withhold stage_done[1]. Expect stage_enable[1] high for 4 cycles, then error=1 and err_stage=1. clear_err → IDLE, error=0.
- Done on expiry cycle, TIMEOUT=4: assert stage_done[0] on the 4th active cycle. Expect stage 1 enabled and no error.
- Abort mid-RUN at stage 0 → enables 0 next cycle, no frame_done, frame_count unchanged. A subsequent start completes a normal frame.
- Continuous mode, NUM_STAGES=3, FRAME_W=2: run 5 frames. Expect start_conversion coincident with each frame_done, and frame_count sequence 1,2,3,0,1. A spurious stage_done[2] asserted during stage 0 is ignored.

Source files
------------

// File: rtl/stage_seq_pkg.sv
// Shared types and helpers for the stage sequencer: FSM state encoding and
// the width derivation used for the binary stage index.
package stage_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CONV  = 2'd1,
    ST_RUN   = 2'd2,
    ST_ERROR = 2'd3
  } state_e;

  // A single stage still needs one index bit.
  function automatic int stage_w_f(input int num_stages);
    if (num_stages <= 32'sd1) begin
      return 32'sd1;
    end else begin
      return $clog2(num_stages);
    end
  endfunction

endpackage

// File: rtl/stage_sequencer_if.sv
// Handshake bundle between the sequencer (master) and the ADC/datapath side (slave).
interface stage_sequencer_if #(
  parameter int NUM_STAGES = 2,
  parameter int FRAME_W    = 8
);
  import stage_seq_pkg::*;

  localparam int STAGE_W = stage_w_f(NUM_STAGES);

  logic                  start;
  logic                  continuous;
  logic                  abort;
  logic                  clear_err;
  logic                  data_ready;
  logic [NUM_STAGES-1:0] stage_done;
  logic                  start_conversion;
  logic [NUM_STAGES-1:0] stage_enable;
  logic                  busy;
  logic                  frame_done;
  logic                  error;
  logic [STAGE_W-1:0]    err_stage;
  logic [FRAME_W-1:0]    frame_count;

  modport master (
    input  start, continuous, abort, clear_err, data_ready, stage_done,
    output start_conversion, stage_enable, busy, frame_done, error, err_stage, frame_count
  );

  modport slave (
    output start, continuous, abort, clear_err, data_ready, stage_done,
    input  start_conversion, stage_enable, busy, frame_done, error, err_stage, frame_count
  );

endinterface

// File: rtl/stage_sequencer_timer.sv
// Per-stage watchdog: counts active cycles and flags the cycle on which the
// stage has been enabled for TIMEOUT cycles.
module stage_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + CNT_W'(1);
    end else begin
      count_d = count_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Count starts at 0 on the first active cycle, so TIMEOUT-1 marks the last one.
  assign expired = enable && !clear && (count_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/stage_sequencer.sv
// Conversion -> processing chain sequencer: requests a conversion, then walks
// NUM_STAGES stages with enable/done handshakes under a per-stage watchdog.
module stage_sequencer
  import stage_seq_pkg::*;
#(
  parameter int NUM_STAGES = 2,
  parameter int TIMEOUT    = 255,
  parameter int FRAME_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  stage_sequencer_if.master bus
);

  localparam int STAGE_W = stage_w_f(NUM_STAGES);

  state_e                state_q, state_d;
  logic [STAGE_W-1:0]    idx_q, idx_d;
  logic                  start_conversion_q, start_conversion_d;
  logic [NUM_STAGES-1:0] stage_enable_q, stage_enable_d;
  logic                  busy_q, busy_d;
  logic                  frame_done_q, frame_done_d;
  logic                  error_q, error_d;
  logic [STAGE_W-1:0]    err_stage_q, err_stage_d;
  logic [FRAME_W-1:0]    frame_count_q, frame_count_d;

  logic timer_clear_s;
  logic timer_en_s;
  logic timer_expired_s;
  logic active_done_s;
  logic last_stage_s;

  assign active_done_s = bus.stage_done[idx_q];
  assign last_stage_s  = (idx_q == STAGE_W'(NUM_STAGES - 1));
  assign timer_en_s    = (state_q == ST_RUN);

  generate
    if (TIMEOUT > 0) begin : g_timer
      stage_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (timer_clear_s),
        .enable  (timer_en_s),
        .expired (timer_expired_s)
      );
    end else begin : g_no_timer
      assign timer_expired_s = 1'b0;
    end
  endgenerate

  // Priority within RUN: abort, then the active stage's done, then the watchdog.
  always_comb begin
    state_d            = state_q;
    idx_d              = idx_q;
    start_conversion_d = 1'b0;
    frame_done_d       = 1'b0;
    frame_count_d      = frame_count_q;
    err_stage_d        = err_stage_q;
    timer_clear_s      = 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d            = ST_CONV;
          start_conversion_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CONV: begin
        if (bus.abort) begin
          state_d = ST_IDLE;
        end else if (bus.data_ready) begin
          state_d = ST_RUN;
          idx_d   = '0;
        end else begin
          state_d = ST_CONV;
        end
      end
      ST_RUN: begin
        timer_clear_s = 1'b0;
        if (bus.abort) begin
          state_d = ST_IDLE;
          idx_d   = '0;
        end else if (active_done_s) begin
          timer_clear_s = 1'b1;
          if (last_stage_s) begin
            idx_d         = '0;
            frame_done_d  = 1'b1;
            frame_count_d = frame_count_q + FRAME_W'(1);
            if (bus.continuous) begin
              state_d            = ST_CONV;
              start_conversion_d = 1'b1;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            idx_d = idx_q + STAGE_W'(1);
          end
        end else if (timer_expired_s) begin
          state_d     = ST_ERROR;
          err_stage_d = idx_q;
          idx_d       = '0;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_ERROR: begin
        if (bus.abort || bus.clear_err) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_ERROR;
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase

    stage_enable_d = (state_d == ST_RUN) ? (NUM_STAGES'(1) << idx_d) : '0;
    busy_d         = (state_d == ST_CONV) || (state_d == ST_RUN);
    error_d        = (state_d == ST_ERROR);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q            <= ST_IDLE;
      idx_q              <= '0;
      start_conversion_q <= 1'b0;
      stage_enable_q     <= '0;
      busy_q             <= 1'b0;
      frame_done_q       <= 1'b0;
      error_q            <= 1'b0;
      err_stage_q        <= '0;
      frame_count_q      <= '0;
    end else begin
      state_q            <= state_d;
      idx_q              <= idx_d;
      start_conversion_q <= start_conversion_d;
      stage_enable_q     <= stage_enable_d;
      busy_q             <= busy_d;
      frame_done_q       <= frame_done_d;
      error_q            <= error_d;
      err_stage_q        <= err_stage_d;
      frame_count_q      <= frame_count_d;
    end
  end

  assign bus.start_conversion = start_conversion_q;
  assign bus.stage_enable     = stage_enable_q;
  assign bus.busy             = busy_q;
  assign bus.frame_done       = frame_done_q;
  assign bus.error            = error_q;
  assign bus.err_stage        = err_stage_q;
  assign bus.frame_count      = frame_count_q;

endmodule

// File: tb/tb_stage_sequencer.sv
// Self-checking bench for stage_sequencer: directed scenarios plus random
// handshakes, compared each cycle against a phase-level reference model.
module tb_stage_sequencer;
  import stage_seq_pkg::*;

  localparam int N  = 3;
  localparam int TO = 5;
  localparam int FW = 2;
  localparam int SW = stage_w_f(N);

  localparam int M_IDLE = 0;
  localparam int M_CONV = 1;
  localparam int M_RUN  = 2;
  localparam int M_ERR  = 3;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  stage_sequencer_if #(.NUM_STAGES(N), .FRAME_W(FW)) bus ();

  stage_sequencer #(.NUM_STAGES(N), .TIMEOUT(TO), .FRAME_W(FW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: phase, active stage, cycles the stage has been enabled.
  int m_mode, m_stage, m_act, m_frames, m_err_stage;
  bit m_sc, m_fd;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_stage = 0; m_act = 0; m_frames = 0; m_err_stage = 0;
    m_sc = 1'b0; m_fd = 1'b0;
  endtask

  task automatic model_next(input bit st, input bit cont, input bit ab, input bit clr,
                            input bit dr, input logic [N-1:0] dn);
    m_sc = 1'b0;
    m_fd = 1'b0;
    case (m_mode)
      M_IDLE: if (st) begin m_mode = M_CONV; m_sc = 1'b1; end
      M_CONV: begin
        if (ab) m_mode = M_IDLE;
        else if (dr) begin m_mode = M_RUN; m_stage = 0; m_act = 1; end
      end
      M_RUN: begin
        if (ab) m_mode = M_IDLE;
        else if (dn[m_stage]) begin
          if (m_stage < N - 1) begin
            m_stage++; m_act = 1;
          end else begin
            m_frames++; m_fd = 1'b1;
            if (cont) begin m_mode = M_CONV; m_sc = 1'b1; end
            else m_mode = M_IDLE;
          end
        end else if (TO != 0 && m_act == TO) begin
          m_mode = M_ERR; m_err_stage = m_stage;
        end else m_act++;
      end
      default: if (ab || clr) m_mode = M_IDLE;
    endcase
  endtask

  task automatic check_outputs();
    check_eq("start_conversion", 32'(bus.start_conversion), 32'(m_sc));
    check_eq("stage_enable", 32'(bus.stage_enable), (m_mode == M_RUN) ? (32'd1 << m_stage) : 32'd0);
    check_eq("busy", 32'(bus.busy), 32'((m_mode == M_CONV) || (m_mode == M_RUN)));
    check_eq("frame_done", 32'(bus.frame_done), 32'(m_fd));
    check_eq("error", 32'(bus.error), 32'(m_mode == M_ERR));
    check_eq("err_stage", 32'(bus.err_stage), 32'(m_err_stage));
    check_eq("frame_count", 32'(bus.frame_count), 32'(m_frames % (1 << FW)));
  endtask

  // One cycle: check what the last edge produced, drive new inputs, advance the model.
  task automatic step(input bit st, input bit cont, input bit ab, input bit clr,
                      input bit dr, input logic [N-1:0] dn);
    check_outputs();
    bus.start      = st;
    bus.continuous = cont;
    bus.abort      = ab;
    bus.clear_err  = clr;
    bus.data_ready = dr;
    bus.stage_done = dn;
    model_next(st, cont, ab, clr, dr, dn);
    @(negedge clk);
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
  endtask

  initial begin
    bus.start = 1'b0; bus.continuous = 1'b0; bus.abort = 1'b0;
    bus.clear_err = 1'b0; bus.data_ready = 1'b0; bus.stage_done = '0;
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    idle_steps(2);

    // Minimum frame: every handshake answered immediately.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b001);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b010);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b100);
    idle_steps(2);

    // Stage 1 never finishes: watchdog trips, start ignored in ERROR, then clear.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b001);
    idle_steps(TO + 1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000);
    idle_steps(1);

    // Done on the expiry cycle of stage 0 counts as success.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000);
    idle_steps(TO - 1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b001);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b010);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b100);

    // Abort in stage 0, then a clean frame.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b001);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b010);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b100);

    // Asynchronous reset in the middle of stage 1.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b001);
    check_outputs();
    #2 reset = 1'b0;
    #1;
    check_eq("async_stage_enable", 32'(bus.stage_enable), 32'd0);
    check_eq("async_busy", 32'(bus.busy), 32'd0);
    check_eq("async_frame_count", 32'(bus.frame_count), 32'd0);
    bus.stage_done = '0;
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    idle_steps(1);

    // Continuous: five back-to-back frames, spurious done[2] during stage 0.
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000);
    for (int f = 0; f < 5; f++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000);
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'b000);
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b100);
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b001);
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b010);
      step(1'b0, (f != 4), 1'b0, 1'b0, 1'b0, 3'b100);
    end
    idle_steps(2);

    // Random handshakes.
    for (int i = 0; i < 3000; i++) begin
      logic [N-1:0] dn;
      for (int b = 0; b < N; b++) dn[b] = ($urandom_range(0, 3) == 0);
      step(($urandom_range(0, 2) == 0), $urandom_range(0, 1) == 1,
           ($urandom_range(0, 29) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 2) == 0), dn);
    end
    check_outputs();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
